// File: rtl/des_pkg.sv
// DES constants, permutation/S-box tables and bit-level helper functions.
// DES bit n of a W-bit vector lives at index W-n throughout.
package des_pkg;

    localparam int NUM_ROUNDS  = 16;
    localparam int DES_BLOCK_W = 64;
    localparam int DES_KEY_W   = 64;
    localparam int HALF_W      = 32;
    localparam int CD_W        = 28;

    typedef enum logic [1:0] {IDLE, ROUND, HOLD} des_state_t;

    localparam logic [5:0] E_TABLE [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

    localparam logic [5:0] P_TABLE [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

    localparam logic [6:0] PC1_TABLE [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

    localparam logic [5:0] PC2_TABLE [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

    // Encrypt left-rotation amount per round (index 0 = round 1).
    localparam logic [1:0] SHIFT_SCHEDULE [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // S-boxes stored row-major: entry = row*16 + column.
    localparam logic [3:0] S1 [64] = '{
        14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
         0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
         4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
        15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13};
    localparam logic [3:0] S2 [64] = '{
        15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
         3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
         0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
        13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9};
    localparam logic [3:0] S3 [64] = '{
        10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
        13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
        13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
         1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12};
    localparam logic [3:0] S4 [64] = '{
         7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
        13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
        10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
         3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14};
    localparam logic [3:0] S5 [64] = '{
         2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
        14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
         4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
        11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3};
    localparam logic [3:0] S6 [64] = '{
        12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
        10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
         9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
         4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13};
    localparam logic [3:0] S7 [64] = '{
         4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
        13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
         1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
         6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12};
    localparam logic [3:0] S8 [64] = '{
        13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
         1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
         7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
         2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11};

    function automatic logic [47:0] perm_e(input logic [31:0] r);
        logic [47:0] o;
        logic [5:0]  idx;
        o = '0;
        for (int i = 0; i < 48; i++) begin
            idx       = 6'd32 - E_TABLE[i];
            o[47 - i] = r[idx[4:0]];
        end
        return o;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] s);
        logic [31:0] o;
        logic [5:0]  idx;
        o = '0;
        for (int i = 0; i < 32; i++) begin
            idx       = 6'd32 - P_TABLE[i];
            o[31 - i] = s[idx[4:0]];
        end
        return o;
    endfunction

    // Drops the eight parity bits and returns {C0, D0}.
    function automatic logic [55:0] perm_pc1(input logic [63:0] k);
        logic [55:0] o;
        logic [6:0]  idx;
        o = '0;
        for (int i = 0; i < 56; i++) begin
            idx       = 7'd64 - PC1_TABLE[i];
            o[55 - i] = k[idx[5:0]];
        end
        return o;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] cd);
        logic [47:0] o;
        logic [5:0]  idx;
        o = '0;
        for (int i = 0; i < 48; i++) begin
            idx       = 6'd56 - PC2_TABLE[i];
            o[47 - i] = cd[idx];
        end
        return o;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        logic [27:0] o;
        case (n)
            2'd1:    o = {x[26:0], x[27]};
            2'd2:    o = {x[25:0], x[27:26]};
            default: o = x;
        endcase
        return o;
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        logic [27:0] o;
        case (n)
            2'd1:    o = {x[0], x[27:1]};
            2'd2:    o = {x[1:0], x[27:2]};
            default: o = x;
        endcase
        return o;
    endfunction

    // Row = outer bits {b1,b6}, column = inner bits b2..b5.
    function automatic logic [3:0] sbox_lookup(input logic [2:0] n, input logic [5:0] b);
        logic [5:0] a;
        logic [3:0] o;
        a = {b[5], b[0], b[4:1]};
        case (n)
            3'd0:    o = S1[a];
            3'd1:    o = S2[a];
            3'd2:    o = S3[a];
            3'd3:    o = S4[a];
            3'd4:    o = S5[a];
            3'd5:    o = S6[a];
            3'd6:    o = S7[a];
            default: o = S8[a];
        endcase
        return o;
    endfunction

endpackage

// File: rtl/des_f_function.sv
// DES round function f(R,K) = P(S(E(R) ^ K)), purely combinational.
module des_f_function
    import des_pkg::*;
(
    input  logic [31:0] i_r,
    input  logic [47:0] i_k,
    output logic [31:0] o_f
);

    logic [47:0] w_x;
    logic [31:0] w_s;

    assign w_x = perm_e(i_r) ^ i_k;

    // Eight 6->4 substitutions; S1 takes the most significant 6-bit group.
    always_comb begin
        w_s = '0;
        for (int j = 0; j < 8; j++) begin
            w_s[31 - 4*j -: 4] = sbox_lookup(3'(j), w_x[47 - 6*j -: 6]);
        end
    end

    assign o_f = perm_p(w_s);

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES Feistel core: one round per clock, 16 rounds, owns the key
// schedule. Input is IP-permuted; output is the pre-output {R16,L16}.
module des_round_engine #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic        i_decrypt,
    input  logic [63:0] i_block_in,
    input  logic [63:0] i_key_in,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [63:0] o_block_out
);
    import des_pkg::*;

    generate
        if (NUM_ROUNDS != des_pkg::NUM_ROUNDS) begin : g_bad_rounds
            $error("des_round_engine supports only 16 rounds");
        end
    endgenerate

    des_state_t  r_state, w_state_nxt;
    logic [4:0]  r_round;
    logic        r_decrypt;
    logic [31:0] r_l, r_r;
    logic [27:0] r_c, r_d;
    logic [63:0] r_block_out;
    logic        r_out_valid;

    logic        w_last;
    logic [3:0]  w_enc_idx, w_dec_idx;
    logic [1:0]  w_shift;
    logic [27:0] w_c_rot, w_d_rot;
    logic [47:0] w_k;
    logic [31:0] w_f, w_r_nxt;
    logic [55:0] w_pc1;

    assign w_last      = (r_state == ROUND) && (r_round == 5'(NUM_ROUNDS));
    assign w_pc1       = perm_pc1(i_key_in);
    assign o_in_ready  = (r_state == IDLE) && i_rst_n;
    assign o_out_valid = r_out_valid;
    assign o_block_out = r_block_out;

    // Decrypt walks the encrypt schedule backwards: round r undoes the
    // rotation of encrypt round 18-r, and round 1 uses C16/D16 = C0/D0.
    assign w_enc_idx = 4'(r_round - 5'd1);
    assign w_dec_idx = 4'(5'd17 - r_round);

    // Pick this round's rotation amount for the active mode.
    always_comb begin
        w_shift = SHIFT_SCHEDULE[w_enc_idx];
        if (r_decrypt) begin
            w_shift = (r_round == 5'd1) ? 2'd0 : SHIFT_SCHEDULE[w_dec_idx];
        end
    end

    assign w_c_rot = r_decrypt ? rotr28(r_c, w_shift) : rotl28(r_c, w_shift);
    assign w_d_rot = r_decrypt ? rotr28(r_d, w_shift) : rotl28(r_d, w_shift);
    assign w_k     = perm_pc2({w_c_rot, w_d_rot});

    des_f_function u_f (
        .i_r (r_r),
        .i_k (w_k),
        .o_f (w_f)
    );

    assign w_r_nxt = r_l ^ w_f;

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state: accept -> 16 rounds -> hold until downstream takes it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_in_valid)  w_state_nxt = ROUND;
            ROUND:   if (w_last)      w_state_nxt = HOLD;
            HOLD:    if (i_out_ready) w_state_nxt = IDLE;
            default:                  w_state_nxt = IDLE;
        endcase
    end

    // Datapath: load on accept, one Feistel round per cycle, hold result.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_round     <= '0;
            r_decrypt   <= 1'b0;
            r_l         <= '0;
            r_r         <= '0;
            r_c         <= '0;
            r_d         <= '0;
            r_block_out <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_in_valid) begin
                        r_l       <= i_block_in[63:32];
                        r_r       <= i_block_in[31:0];
                        r_c       <= w_pc1[55:28];
                        r_d       <= w_pc1[27:0];
                        r_decrypt <= i_decrypt;
                        r_round   <= 5'd1;
                    end
                end
                ROUND: begin
                    r_l     <= r_r;
                    r_r     <= w_r_nxt;
                    r_c     <= w_c_rot;
                    r_d     <= w_d_rot;
                    r_round <= r_round + 5'd1;
                    if (w_last) begin
                        // Halves are left swapped; inverse IP follows directly.
                        r_block_out <= {w_r_nxt, r_r};
                        r_out_valid <= 1'b1;
                        r_round     <= '0;
                    end
                end
                HOLD: begin
                    if (i_out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
